// File: rtl/duplicated_sum_checker.sv
// duplicated_sum_checker
// Consumer-side checker for a duplicated (dual-rail) carry-select adder.
// Each accepted result {s, s_invert, papb, pab} is checked for:
//   - dual-rail complement (s_invert must equal ~s)       -> err_rail
//   - operand parity consistency (papb must equal pab)    -> err_par
//   - optional sum parity ((^s) ^ pab ^ pc must be zero)  -> err_sum
// Two-stage valid/ready pipeline; statistics and the alarm FSM advance on
// output transfers only.
//
// Optional feature macro: DSC_SUM_PARITY_CHECK_EN (adds pc input, err_sum
// output, and folds err_sum into err_any).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   s, s_invert           true / complement rail sums (WIDTH bits)
//   papb, pab             parity signals from the adder
//   pc                    carry-in vector parity (only with the macro)
//   out_valid / out_ready output handshake
//   out_sum               registered s
//   err_rail, err_par     per-result error flags
//   err_sum               per-result sum parity error (only with the macro)
//   err_any               OR of enabled flags
//   err_cnt               saturating count of erroneous output transfers
//   alarm                 sticky alarm, cleared by clear
//   clear                 synchronous clear of err_cnt, alarm and FSM
module duplicated_sum_checker #(
    parameter int WIDTH        = 78,
    parameter int ALARM_THRESH = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] s_invert,
    input  logic             papb,
    input  logic             pab,
`ifdef DSC_SUM_PARITY_CHECK_EN
    input  logic             pc,
    output logic             err_sum,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             err_rail,
    output logic             err_par,
    output logic             err_any,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm,
    input  logic             clear
);

    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_ALARM} state_t;

    localparam logic [3:0] THRESH4 = 4'(ALARM_THRESH);

    // in_ready is held low until the first clock after reset release.
    logic             ready_en_reg;

    logic             s1_full_reg;
    logic [WIDTH-1:0] s1_s_reg;
    logic [WIDTH-1:0] s1_si_reg;
    logic             s1_papb_reg;
    logic             s1_pab_reg;
    logic [WIDTH-1:0] eq_vec;

    logic             s2_full_reg;
    logic [WIDTH-1:0] out_sum_reg;
    logic             err_rail_reg;
    logic             err_par_reg;

    logic             s2_move;
    logic             in_xfer;
    logic             out_xfer;

    state_t           state_reg, state_next;
    logic [3:0]       consec_reg, consec_next, consec_inc;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign s2_move  = !s2_full_reg || out_ready;
    assign in_ready = ready_en_reg && (!s1_full_reg || s2_move);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_full_reg && out_ready;

    // A bit where both rails agree is a rail fault.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_eq
            assign eq_vec[gi] = ~(s1_s_reg[gi] ^ s1_si_reg[gi]);
        end
    endgenerate

`ifdef DSC_SUM_PARITY_CHECK_EN
    logic s1_pc_reg;
    logic err_sum_reg;
    assign err_sum = err_sum_reg;
    assign err_any = err_rail_reg | err_par_reg | err_sum_reg;
`else
    assign err_any = err_rail_reg | err_par_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
            s1_full_reg  <= 1'b0;
            s1_s_reg     <= '0;
            s1_si_reg    <= '0;
            s1_papb_reg  <= 1'b0;
            s1_pab_reg   <= 1'b0;
            s2_full_reg  <= 1'b0;
            out_sum_reg  <= '0;
            err_rail_reg <= 1'b0;
            err_par_reg  <= 1'b0;
`ifdef DSC_SUM_PARITY_CHECK_EN
            s1_pc_reg    <= 1'b0;
            err_sum_reg  <= 1'b0;
`endif
        end else begin
            ready_en_reg <= 1'b1;
            // Stage 1: load on input transfer, otherwise empties when it
            // hands its content to stage 2.
            if (in_xfer) begin
                s1_full_reg <= 1'b1;
                s1_s_reg    <= s;
                s1_si_reg   <= s_invert;
                s1_papb_reg <= papb;
                s1_pab_reg  <= pab;
`ifdef DSC_SUM_PARITY_CHECK_EN
                s1_pc_reg   <= pc;
`endif
            end else if (s2_move) begin
                s1_full_reg <= 1'b0;
            end
            // Stage 2: holds while stalled so outputs stay stable.
            if (s2_move) begin
                s2_full_reg <= s1_full_reg;
                if (s1_full_reg) begin
                    out_sum_reg  <= s1_s_reg;
                    err_rail_reg <= |eq_vec;
                    err_par_reg  <= s1_papb_reg ^ s1_pab_reg;
`ifdef DSC_SUM_PARITY_CHECK_EN
                    err_sum_reg  <= (^s1_s_reg) ^ s1_pab_reg ^ s1_pc_reg;
`endif
                end
            end
        end
    end

    assign out_valid = s2_full_reg;
    assign out_sum   = out_sum_reg;
    assign err_rail  = err_rail_reg;
    assign err_par   = err_par_reg;

    // Alarm FSM and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_OK;
            consec_reg <= 4'd0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            consec_reg <= consec_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign consec_inc = (consec_reg == 4'hF) ? 4'hF : consec_reg + 4'd1;

    always_comb begin
        state_next  = state_reg;
        consec_next = consec_reg;
        cnt_next    = cnt_reg;
        if (clear) begin
            // clear wins over a coinciding output transfer's update
            state_next  = ST_OK;
            consec_next = 4'd0;
            cnt_next    = '0;
        end else if (out_xfer) begin
            if (err_any && !(&cnt_reg)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            case (state_reg)
                ST_OK: begin
                    if (err_any) begin
                        consec_next = 4'd1;
                        state_next  = (ALARM_THRESH == 1) ? ST_ALARM : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (err_any) begin
                        consec_next = consec_inc;
                        if (consec_inc >= THRESH4) begin
                            state_next = ST_ALARM;
                        end
                    end else begin
                        consec_next = 4'd0;
                        state_next  = ST_OK;
                    end
                end
                ST_ALARM: begin
                    if (err_any) begin
                        consec_next = consec_inc;
                    end
                end
                default: begin
                    state_next  = ST_OK;
                    consec_next = 4'd0;
                end
            endcase
        end
    end

    assign err_cnt = cnt_reg;
    assign alarm   = (state_reg == ST_ALARM);

endmodule

// File: tb/tb_duplicated_sum_checker.sv
// Testbench for duplicated_sum_checker: directed stimulus, a queue-based
// reference model checked every cycle, plus literal expectations.
module tb_duplicated_sum_checker;

    localparam int W      = 78;
    localparam int THRESH = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  s, s_invert;
    logic          papb, pab, pc;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_sum;
    logic          err_rail, err_par, err_any, err_sum;
    logic [CW-1:0] err_cnt;
    logic          alarm, clear;

    int tests = 0;
    int fails = 0;

    duplicated_sum_checker #(.WIDTH(W), .ALARM_THRESH(THRESH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .s_invert(s_invert), .papb(papb), .pab(pab),
`ifdef DSC_SUM_PARITY_CHECK_EN
        .pc(pc), .err_sum(err_sum),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .err_rail(err_rail), .err_par(err_par), .err_any(err_any),
        .err_cnt(err_cnt), .alarm(alarm), .clear(clear)
    );

`ifndef DSC_SUM_PARITY_CHECK_EN
    assign err_sum = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] sv;
        logic         rail;
        logic         par;
        logic         sm;
    } exp_t;

    exp_t q[$];
    int   m_cnt    = 0;
    int   m_consec = 0;
    bit   m_alarm  = 0;
    bit   m_rdy    = 0;

    always @(negedge clk) begin
        exp_t e, ni;
        bit   any;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0; m_consec = 0; m_alarm = 0; m_rdy = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_err_cnt", err_cnt, 0);
            check("rst_alarm", alarm, 0);
        end else begin
            // two slots: full pipeline only accepts if the output drains
            check("in_ready", in_ready, m_rdy && (q.size() < 2 || out_ready));
            check("err_cnt", err_cnt, m_cnt);
            check("alarm", alarm, m_alarm);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("out_valid_spurious", out_valid, 0);
                end else begin
                    e = q[0];
                    any = e.rail | e.par;
`ifdef DSC_SUM_PARITY_CHECK_EN
                    any = any | e.sm;
                    check("err_sum", err_sum, e.sm);
`endif
                    check("out_sum", out_sum, e.sv);
                    check("err_rail", err_rail, e.rail);
                    check("err_par", err_par, e.par);
                    check("err_any", err_any, any);
                    if (out_ready) begin
                        void'(q.pop_front());
                        $display("[TB] out s=%0h rail=%0b par=%0b sum=%0b clr=%0b", e.sv, e.rail, e.par, e.sm, clear);
                        if (!clear && any) begin
                            if (m_cnt < CMAX) m_cnt++;
                            if (m_consec < 15) m_consec++;
                            if (m_consec >= THRESH) m_alarm = 1;
                        end else if (!clear && !m_alarm) begin
                            m_consec = 0;
                        end
                    end
                end
            end
            if (clear) begin
                m_cnt = 0; m_consec = 0; m_alarm = 0;
            end
            if (in_valid && in_ready) begin
                ni.sv   = s;
                ni.rail = ((s ^ s_invert) != {W{1'b1}});
                ni.par  = (papb != pab);
`ifdef DSC_SUM_PARITY_CHECK_EN
                ni.sm   = (^s) ^ pab ^ pc;
`else
                ni.sm   = 1'b0;
`endif
                q.push_back(ni);
            end
            m_rdy = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] sv, input logic [W-1:0] si,
                        input logic pa, input logic pb, input logic pcv);
        in_valid = 1'b1;
        s = sv; s_invert = si; papb = pa; pab = pb; pc = pcv;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] v;
        int acc;
        int guard;
        one = 1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        s = '0; s_invert = '0; papb = 1'b0; pab = 1'b0; pc = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_delay", in_ready, 0);
        step();
        @(negedge clk);
        check("ready_after", in_ready, 1);
        step();

        // Clean stream: out_valid two cycles after the first transfer.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            s = W'(i * 3); s_invert = ~W'(i * 3); papb = 1'b1; pab = 1'b1; pc = 1'b0;
            @(negedge clk);
            check("latency_out_valid", out_valid, (i >= 2));
            step();
        end
        idle(4);
        @(negedge clk);
        check("clean_cnt", err_cnt, 0);
        check("clean_alarm", alarm, 0);
        step();

        // Single-bit rail error on bit 40, then a clean result.
        v = 78'h2A5;
        send(v, ~v ^ (one << 40), 1'b1, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("rail_flag", err_rail, 1);
        check("rail_any", err_any, 1);
        step();
        send(v, ~v, 1'b0, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("rail_cnt", err_cnt, 1);
        step();
        // Back in OK: three more errors must not reach the alarm.
        repeat (3) send(v, ~v, 1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("suspect_no_alarm", alarm, 0);
        check("suspect_cnt", err_cnt, 4);
        step();
        clear = 1'b1; step(); clear = 1'b0;
        @(negedge clk);
        check("clear_cnt", err_cnt, 0);
        step();

        // Four parity mismatches raise the alarm on the fourth.
        repeat (3) send(v, ~v, 1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("par3_alarm", alarm, 0);
        check("par3_cnt", err_cnt, 3);
        step();
        send(v, ~v, 1'b1, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("par4_alarm", alarm, 1);
        check("par4_cnt", err_cnt, 4);
        step();
        clear = 1'b1; step(); clear = 1'b0;
        @(negedge clk);
        check("clear2_alarm", alarm, 0);
        check("clear2_cnt", err_cnt, 0);
        step();

        // clear coinciding with an erroneous output transfer drops the count.
        send(v, ~v, 1'b1, 1'b0, 1'b0);
        idle(1);
        clear = 1'b1; step(); clear = 1'b0;
        idle(2);
        @(negedge clk);
        check("clear_prio_cnt", err_cnt, 0);
        step();

        // Backpressure: only two results fit while the output is stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            s = W'(acc * 37 + 5); s_invert = ~W'(acc * 37 + 5); papb = 1'b0; pab = 1'b0;
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_in_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        guard = 0;
        while (acc < 5 && guard < 20) begin
            in_valid = 1'b1;
            s = W'(acc * 37 + 5); s_invert = ~W'(acc * 37 + 5);
            @(negedge clk);
            if (in_ready) acc++;
            guard++;
            step();
        end
        check("bp_resume", acc, 5);
        idle(4);
        @(negedge clk);
        check("bp_drained", q.size(), 0);
        step();

        // Saturation at 15 with a 4-bit counter, then reset mid-stream.
        for (int i = 0; i < 20; i++) send(W'(i), ~W'(i), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("sat_cnt", err_cnt, CMAX);
        check("sat_alarm", alarm, 1);
        check("sat_out_valid", out_valid, 1);
        step();
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        @(negedge clk);
        check("post_rst_cnt", err_cnt, 0);
        check("post_rst_alarm", alarm, 0);
        step();

`ifdef DSC_SUM_PARITY_CHECK_EN
        send(78'h3, ~78'h3, 1'b1, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("sum_err_pc0", err_sum, 1);
        check("sum_any_pc0", err_any, 1);
        step();
        send(78'h3, ~78'h3, 1'b1, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("sum_err_pc1", err_sum, 0);
        check("sum_any_pc1", err_any, 0);
        step();
        idle(3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
